// File: rtl/pc16_pkg.sv
// ============================================================================
// pc16_pkg : shared widths, limits and per-edge operation decode for pc16
// Revision : 1.0
// ============================================================================
`default_nettype none

package pc16_pkg;

  localparam int          PC_W          = 16;
  localparam logic [15:0] PC_RESET_ADDR = 16'h0000;
  localparam logic [15:0] PC_MAX        = 16'hFFFF;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_INC   = 3'd1,
    OP_LOAD  = 3'd2,
    OP_STALL = 3'd3,
    OP_RESET = 3'd4
  } pc_op_e;

  // Priority: reset > stall > load > inc > hold.
  function automatic pc_op_e pc_decode(input logic reset, input logic stall,
                                       input logic load, input logic inc);
    if (reset)      return OP_RESET;
    else if (stall) return OP_STALL;
    else if (load)  return OP_LOAD;
    else if (inc)   return OP_INC;
    else            return OP_HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc16_inc16.sv
// ============================================================================
// pc16_inc16 : ripple half-adder incrementer, carry-out flags all-ones input
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc16_inc16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum_o[i]   = a_i[i] ^ carry[i];
    assign carry[i+1] = a_i[i] & carry[i];
  end

  assign carry_o = carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/pc16.sv
// ============================================================================
// pc16 : 16-bit program counter with reset/load/increment/hold and wrap flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc16
  import pc16_pkg::*;
#(
  parameter logic [15:0] RESET_ADDR = PC_RESET_ADDR,
  parameter int          WIDTH      = PC_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        inc,
  input  logic        stall,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        wrapped,
  output logic        busy
);

  if (WIDTH != PC_W) begin : g_width_check
    $error("pc16: WIDTH must be 16");
  end

  logic [15:0] out_q, out_d;
  logic        wrapped_q, wrapped_d;
  logic        busy_q, busy_d;
  logic [15:0] inc_val, lvl_inc, lvl_load;
  logic [15:0] m_inc, m_load, m_reset;
  logic        inc_carry;
  logic        en_d;
  pc_op_e      op;

  pc16_inc16 #(.WIDTH(PC_W)) u_inc16 (
    .a_i    (out_q),
    .sum_o  (inc_val),
    .carry_o(inc_carry)
  );

  // Three AND/OR mux levels; reset is last so X on lower levels is masked.
  assign m_inc    = {16{inc}};
  assign m_load   = {16{load}};
  assign m_reset  = {16{reset}};
  assign lvl_inc  = (inc_val & m_inc) | (out_q & ~m_inc);
  assign lvl_load = (in & m_load) | (lvl_inc & ~m_load);
  assign out_d    = (RESET_ADDR & m_reset) | (lvl_load & ~m_reset);

  assign en_d      = ~stall | reset;
  assign op        = pc_decode(reset, stall, load, inc);
  assign wrapped_d = (op == OP_INC) & inc_carry;
  assign busy_d    = (op == OP_STALL) & (load | inc);

  always_ff @(posedge clk) begin
    if (en_d) out_q <= out_d;
    wrapped_q <= wrapped_d;
    busy_q    <= busy_d;
  end

  assign out     = out_q;
  assign wrapped = wrapped_q;
  assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pc16.sv
// ============================================================================
// tb_pc16 : directed vector table plus randomized run against a priority model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc16;

  logic        clk = 1'b0;
  logic        reset, load, inc, stall;
  logic [15:0] din;
  logic [15:0] out_a, out_b;
  logic        wrapped_a, wrapped_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc16 u_dut_a (
    .clk(clk), .reset(reset), .load(load), .inc(inc), .stall(stall),
    .in(din), .out(out_a), .wrapped(wrapped_a), .busy(busy_a)
  );

  pc16 #(.RESET_ADDR(16'h0100)) u_dut_b (
    .clk(clk), .reset(reset), .load(load), .inc(inc), .stall(stall),
    .in(din), .out(out_b), .wrapped(wrapped_b), .busy(busy_b)
  );

  typedef struct {
    logic        rst, stl, ld, ic;
    logic [15:0] d;
    logic [15:0] ea, eb;
    logic        ew, ebusy;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic l, input logic i,
                       input logic [15:0] d);
    reset = r; stall = s; load = l; inc = i; din = d;
    @(posedge clk);
    #1;
  endtask

  // Model state: counter value per instance plus flags.
  int m_a, m_b;
  int m_w, m_busy;

  function automatic int next_pc(int cur, int rst_addr, bit r, bit s, bit l, bit i, int d);
    if (r)      return rst_addr;
    else if (s) return cur;
    else if (l) return d;
    else if (i) return (cur + 1) % 65536;
    else        return cur;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 1'bx, 1'bx, 1'bx, 16'hxxxx, 16'h0000, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0101, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0102, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 16'h0103, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1235, 16'h1235, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h5555, 16'h0001, 16'h0001, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'hABCD, 16'h0000, 16'h0100, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0042, 16'h0042, 16'h0042, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1'b0};

    reset = 1'b0; stall = 1'b0; load = 1'b0; inc = 1'b0; din = 16'h0000;
    @(posedge clk);
    #1;

    for (int v = 0; v < 18; v++) begin
      drive(vecs[v].rst, vecs[v].stl, vecs[v].ld, vecs[v].ic, vecs[v].d);
      check($sformatf("vec%0d out_a", v), out_a, vecs[v].ea);
      check($sformatf("vec%0d out_b", v), out_b, vecs[v].eb);
      check($sformatf("vec%0d wrapped", v), {15'd0, wrapped_a}, {15'd0, vecs[v].ew});
      check($sformatf("vec%0d busy", v), {15'd0, busy_a}, {15'd0, vecs[v].ebusy});
    end

    // Wrap pulse must drop after exactly one cycle even while inc continues.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("wrap pulse hi", {15'd0, wrapped_a}, 16'd1);
    check("wrap pulse b", {15'd0, wrapped_b}, 16'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("wrap pulse lo", {15'd0, wrapped_a}, 16'd0);
    check("post wrap out", out_a, 16'h0001);

    // Randomized run against the priority-table model.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    m_a = 16'h0000; m_b = 16'h0100; m_w = 0; m_busy = 0;
    for (int c = 0; c < 10000; c++) begin
      bit r, s, l, i;
      int d;
      r = ($urandom_range(0, 99) < 5);
      s = ($urandom_range(0, 99) < 20);
      l = ($urandom_range(0, 99) < 20);
      i = ($urandom_range(0, 99) < 70);
      d = ($urandom_range(0, 9) < 2) ? 16'hFFFF - $urandom_range(0, 2) : $urandom_range(0, 65535);
      m_w    = (!r && !s && !l && i && (m_a + 1 > 65535)) ? 1 : 0;
      m_busy = (!r && s && (l || i)) ? 1 : 0;
      m_a    = next_pc(m_a, 16'h0000, r, s, l, i, d);
      m_b    = next_pc(m_b, 16'h0100, r, s, l, i, d);
      drive(r, s, l, i, d[15:0]);
      check("rnd out_a", out_a, m_a[15:0]);
      check("rnd out_b", out_b, m_b[15:0]);
      check("rnd wrapped", {15'd0, wrapped_a}, m_w[15:0]);
      check("rnd busy", {15'd0, busy_a}, m_busy[15:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
